if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the RISC-V pipeline: owns the PC, issues word fetches to instruction memory over a req/ready handshake, and presents fetched instructions to the IF/ID pipeline register. It absorbs variable memory latency, back-pressure from decode, and branch redirects from execute. A one-entry skid buffer allows a fetch to complete while decode is stalled.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- stall_i  input  1  downstream will not capture if_* this cycle
- br_i  input  1  redirect request from EX; single-cycle pulse
- br_target_i  input  32  redirect target, word-aligned
- mem_req_o  output  1  fetch request
- mem_addr_o  output  32  fetch address; stable while mem_req_o=1 and no mem_ready_i
- mem_ready_i  input  1  fetch complete; mem_rdata_i valid this cycle; sampled only when mem_req_o=1
- mem_rdata_i  input  32  fetched instruction
- if_pc_o  output  32  PC of presented instruction
- if_inst_o  output  32  presented instruction
- if_valid_o  output  1  if_pc_o/if_inst_o valid

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE: entered on rst; one cycle; then FETCH with pc=RESET_PC.
- FETCH: mem_req_o=1, mem_addr_o=pc. Memory may assert mem_ready_i in the first cycle of a request.
- Output slot free this cycle: !if_valid_o || !stall_i. Consumption: if_valid_o && !stall_i.
- FETCH, mem_ready_i, no kill: if slot free, load if_pc_o<=pc, if_inst_o<=mem_rdata_i, if_valid_o<=1, pc<=pc+4, stay FETCH; else write pc/data to skid, pc<=pc+4, go HOLD.
- FETCH, no mem_ready_i: hold pc, mem_addr_o; if slot consumed, if_valid_o<=0.
- HOLD: mem_req_o=0. On consumption: skid moves into output regs (if_valid_o stays 1), go FETCH.
- Redirect (br_i=1), highest priority, any state except IDLE:
  - if_valid_o<=0, if_pc_o<=0, if_inst_o<=0, skid cleared.
  - HOLD, or FETCH with mem_ready_i same cycle: data discarded, pc<=br_target_i, next state FETCH.
  - FETCH without mem_ready_i: request stays outstanding at old address; latch target in redir_pc, set kill. On the later mem_ready_i: data discarded, pc<=redir_pc, kill cleared, stay FETCH. A second br_i while kill is set overwrites redir_pc.
  - stall_i ignored in the redirect cycle.
- PC arithmetic: 32-bit, pc+4 wraps 32'hFFFF_FFFC -> 0; no alignment checks.
- Memory-side ordering: at most one outstanding request; no new address until mem_ready_i.

## Timing
- Reset values: state IDLE, pc=RESET_PC, mem_req_o=0, mem_addr_o=RESET_PC, if_pc_o=0, if_inst_o=0, if_valid_o=0, skid empty, kill=0.
- rst mid-request: request abandoned immediately; mem_req_o=0 in the cycle after rst.
- First mem_req_o=1: second cycle after rst deasserts.
- Latency: mem_ready_i at cycle N -> if_valid_o/if_inst_o at cycle N+1.
- Zero-wait-state memory with no stall: one instruction per cycle.
- Stall: if_* outputs are held unchanged while stall_i=1 and if_valid_o=1.
- Redirect: br_i at cycle N -> if_valid_o=0 at N+1. The first target instruction is valid at N+2 with zero-wait memory and no outstanding request. Otherwise it is valid one cycle after the target's mem_ready_i.
- All outputs are registered except mem_req_o and mem_addr_o, which are decoded from state and pc.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory, stall_i=0 -> mem_addr_o 0x100, 0x104, 0x108 on consecutive cycles; if_pc_o follows one cycle later with if_valid_o=1 continuously.
- Memory with 3 wait states -> mem_addr_o is held for 3 cycles; one if_valid_o pulse per fetch; if_pc_o advances by 4 per completed fetch.
- stall_i=1 for 4 cycles while fetch of 0x108 completes -> if_pc_o=0x104 held, state HOLD, mem_req_o=0. Stall release -> if_pc_o=0x108, then fetch of 0x10C.
- br_i with target 0x200 while a 2-wait-state fetch of 0x104 is outstanding -> 0x104 data never presented; if_valid_o=0 until 0x200 is fetched; next mem_addr_o=0x200.
- br_i in the same cycle as mem_ready_i and stall_i=1 -> output cleared next cycle; next request is 0x200; no skid entry retained.
- rst asserted mid-request -> all outputs at reset values next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ready handshake
// and presents them to IF/ID through a one-entry skid buffer; handles EX redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_i,
  input  logic [31:0] br_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] redir_pc, redir_pc_nxt;
  logic        kill, kill_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic [31:0] skid_inst, skid_inst_nxt;
  logic [31:0] if_pc_nxt, if_inst_nxt;
  logic        if_valid_nxt;
  logic        slot_free, consume;

  // Sequential PC advance; wraps naturally at the top of the address space.
  function automatic logic [31:0] pc_inc(input logic [31:0] p);
    return p + 32'd4;
  endfunction

  assign mem_req_o  = (state == FETCH);
  assign mem_addr_o = pc;
  assign slot_free  = !if_valid_o || !stall_i;
  assign consume    = if_valid_o && !stall_i;

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    redir_pc_nxt  = redir_pc;
    kill_nxt      = kill;
    skid_pc_nxt   = skid_pc;
    skid_inst_nxt = skid_inst;
    if_pc_nxt     = if_pc_o;
    if_inst_nxt   = if_inst_o;
    if_valid_nxt  = if_valid_o;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
        pc_nxt    = RESET_PC;
      end
      FETCH: begin
        if (br_i) begin
          if_valid_nxt  = 1'b0;
          if_pc_nxt     = '0;
          if_inst_nxt   = '0;
          skid_pc_nxt   = '0;
          skid_inst_nxt = '0;
          if (mem_ready_i) begin
            pc_nxt   = br_target_i;
            kill_nxt = 1'b0;
          end else begin
            // Outstanding request must finish at its old address; its data is dropped.
            redir_pc_nxt = br_target_i;
            kill_nxt     = 1'b1;
          end
        end else if (mem_ready_i) begin
          if (kill) begin
            pc_nxt   = redir_pc;
            kill_nxt = 1'b0;
            if (consume) if_valid_nxt = 1'b0;
          end else if (slot_free) begin
            if_pc_nxt    = pc;
            if_inst_nxt  = mem_rdata_i;
            if_valid_nxt = 1'b1;
            pc_nxt       = pc_inc(pc);
          end else begin
            skid_pc_nxt   = pc;
            skid_inst_nxt = mem_rdata_i;
            pc_nxt        = pc_inc(pc);
            state_nxt     = HOLD;
          end
        end else if (consume) begin
          if_valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (br_i) begin
          if_valid_nxt  = 1'b0;
          if_pc_nxt     = '0;
          if_inst_nxt   = '0;
          skid_pc_nxt   = '0;
          skid_inst_nxt = '0;
          pc_nxt        = br_target_i;
          state_nxt     = FETCH;
        end else if (consume) begin
          if_pc_nxt   = skid_pc;
          if_inst_nxt = skid_inst;
          state_nxt   = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      redir_pc   <= '0;
      kill       <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
      if_pc_o    <= '0;
      if_inst_o  <= '0;
      if_valid_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      redir_pc   <= redir_pc_nxt;
      kill       <= kill_nxt;
      skid_pc    <= skid_pc_nxt;
      skid_inst  <= skid_inst_nxt;
      if_pc_o    <= if_pc_nxt;
      if_inst_o  <= if_inst_nxt;
      if_valid_o <= if_valid_nxt;
    end
  end

endmodule
